// File: rtl/approx_adder_err_monitor.sv
// Error-statistics monitor for N-bit approximate adders: exact vs approx, ED stats.
// Optional APPROX_MON_SQERR_EN adds a saturating sum of squared ED (sum_sq_ed).
module approx_adder_err_monitor #(
  parameter int unsigned N     = 16,
  parameter int unsigned CNT_W = 32,
  parameter int unsigned ACC_W = 48
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] cfg_num_samples,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_x,
  input  logic [N-1:0]     in_y,
  input  logic [N-1:0]     in_s,
  input  logic             in_co,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] sample_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [N:0]       max_ed,
  output logic [ACC_W-1:0] sum_ed
`ifdef APPROX_MON_SQERR_EN
  ,
  output logic [2*ACC_W-1:0] sum_sq_ed
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_q;
  logic [CNT_W-1:0] rem_q;
  logic             v1_q;
  logic [N:0]       exact_q;
  logic [N:0]       approx_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] err_q;
  logic [N:0]       max_q;
  logic [ACC_W-1:0] sum_q;

  logic             xfer;
  logic             start_ok;
  logic [N:0]       ed;
  logic [ACC_W:0]   sum_ext;
  logic [ACC_W-1:0] sum_d;

  assign in_ready = (state_q == RUN) && (rem_q != '0);
  assign xfer     = in_valid && in_ready;
  assign start_ok = start && ((state_q == IDLE) || (state_q == DONE));
  assign busy     = (state_q == RUN) || (state_q == DRAIN);
  assign done     = (state_q == DONE);

  assign sample_cnt = cnt_q;
  assign err_cnt    = err_q;
  assign max_ed     = max_q;
  assign sum_ed     = sum_q;

  // Unsigned error distance between the registered exact and approximate sums
  always_comb begin
    ed = '0;
    if (exact_q >= approx_q) ed = exact_q - approx_q;
    else                     ed = approx_q - exact_q;
  end

  // Saturating ED accumulation
  always_comb begin
    sum_ext = {1'b0, sum_q} + {{(ACC_W-N){1'b0}}, ed};
    sum_d   = sum_ext[ACC_W] ? '1 : sum_ext[ACC_W-1:0];
  end

`ifdef APPROX_MON_SQERR_EN
  logic [2*ACC_W-1:0] sq_q;
  logic [2*N+1:0]     sq;
  logic [2*ACC_W:0]   sq_ext;
  logic [2*ACC_W-1:0] sq_d;

  assign sum_sq_ed = sq_q;

  // Saturating squared-ED accumulation
  always_comb begin
    sq     = ed * ed;
    sq_ext = {1'b0, sq_q} + {{(2*ACC_W-2*N-1){1'b0}}, sq};
    sq_d   = sq_ext[2*ACC_W] ? '1 : sq_ext[2*ACC_W-1:0];
  end

  // Squared-ED register follows the same clear/update rules as sum_ed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        sq_q <= '0;
    else if (start_ok) sq_q <= '0;
    else if (v1_q)     sq_q <= sq_d;
  end
`endif

  // Run control: state and remaining-sample counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rem_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q <= RUN;
            rem_q   <= cfg_num_samples;
          end
        end
        RUN: begin
          if (xfer)          rem_q   <= rem_q - ONE;
          if (rem_q == '0)   state_q <= DRAIN;
        end
        DRAIN: begin
          if (!v1_q) state_q <= DONE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Stage 1: capture exact and approximate sums on each transfer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q     <= 1'b0;
      exact_q  <= '0;
      approx_q <= '0;
    end else begin
      v1_q <= xfer;
      if (xfer) begin
        exact_q  <= {1'b0, in_x} + {1'b0, in_y};
        approx_q <= {in_co, in_s};
      end
    end
  end

  // Stage 2: clear on an accepted start, otherwise fold in each stage-1 sample
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      err_q <= '0;
      max_q <= '0;
      sum_q <= '0;
    end else if (start_ok) begin
      cnt_q <= '0;
      err_q <= '0;
      max_q <= '0;
      sum_q <= '0;
    end else if (v1_q) begin
      cnt_q <= cnt_q + ONE;
      if (ed != '0) err_q <= err_q + ONE;
      if (ed > max_q) max_q <= ed;
      sum_q <= sum_d;
    end
  end

endmodule
